flex_timer: RTL
===============

# flex_timer

Parametrised up/down counter/timer: the next generation of the team's flex counter, adding direction control, synchronous clear and load, wrap/saturate/one-shot modes, and a registered event pulse. It sits under the protocol and timing controllers as the common bit, byte and timeout counter, and is instanced wherever a bare flex counter is too limited.

## Interface

- NUM_CNT_BITS, 4, counter width N (≥2).
- PRESCALE_BITS, 4, prescaler width P (used only with FLEX_TIMER_PRESCALE_EN).
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear.
- load_en  in  1  synchronous load of load_val.
- load_val  in  N  load value.
- count_enable  in  1  step enable (wrap/saturate modes); start strobe (one-shot mode).
- count_down  in  1  0 = up, 1 = down.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- rollover_val  in  N  terminal value for up counting and reload value for down counting; sampled every cycle.
- prescale_val  in  P  tick divider (present only with FLEX_TIMER_PRESCALE_EN).
- count_out  out  N  registered count.
- rollover_flag  out  1  combinational; high while count_out == terminal (up: count_out ≥ rollover_val; down: count_out == 0).
- rollover_pulse  out  1  registered one-cycle event pulse.
- busy  out  1  registered; high while one-shot is in RUN.

## Operation

- Per-edge priority: clear > load_en > step. clear sets count_out = 0 and state = IDLE. load_en sets count_out = load_val and state = IDLE. Neither clear nor load pulses rollover_pulse.
- step = tick && (count_enable in wrap/saturate; state == RUN in one-shot). Without the prescaler, tick = 1.
- Up step: if count_out ≥ rollover_val, the terminal step applies; otherwise count_out + 1.
- Down step: if count_out == 0, the terminal step applies; otherwise count_out − 1. Values above rollover_val decrement normally.
- Wrap terminal step: up goes to 0, down goes to rollover_val. rollover_pulse = 1.
- Saturate: count_out holds at terminal. rollover_pulse fires only on the step that arrives at terminal, never while holding.
- One-shot FSM:
  - IDLE → RUN on count_enable. No step happens on the start edge.
  - RUN steps on every tick, ignoring count_enable.
  - RUN → DONE on the step that reaches terminal, with rollover_pulse = 1.
  - DONE holds count_out. count_enable is ignored in DONE.
  - DONE → IDLE only on clear or load_en.
- Leaving mode 10 from any state forces IDLE on the next edge. Direction change mid-run takes effect on the next step.
- rollover_val = 0 counting up: every step is terminal (count stays 0, pulse on every step in wrap mode).
- All arithmetic is N-bit unsigned with no carry out.

## Timing

- Reset values: count_out = 0, rollover_pulse = 0, busy = 0, state IDLE, prescaler = 0. After reset, rollover_flag = 1 if count_down = 1 (count is 0).
- count_out updates on the edge that samples step/clear/load, so latency is one cycle.
- rollover_pulse is high for exactly the one cycle in which count_out shows the post-event value.
- busy rises the cycle after the start edge and falls in the same cycle as the terminal rollover_pulse.
- Asynchronous reset mid-run aborts immediately. No pulse is generated.

## Configuration

- FLEX_TIMER_PRESCALE_EN defined:
  - The prescale_val port and a P-bit prescaler are present.
  - The prescaler increments each cycle while stepping is requested (count_enable or RUN).
  - tick = 1 when prescaler == prescale_val; the prescaler then returns to 0.
  - prescale_val = 0 gives a tick every cycle.
  - clear and load_en zero the prescaler.
- Not defined: no prescale_val port, tick is constantly 1, and behaviour is identical to prescale_val = 0.

## Test plan

- Wrap up, N=4: rollover_val = 5, count_enable held → count 0,1,2,3,4,5,0. rollover_pulse only in the cycle count_out = 0 after 5. rollover_flag high while count is 5.
- Wrap down: load_val = 2 → count 2,1,0,5,4 with rollover_val = 5. Pulse when 5 appears.
- Saturate up: rollover_val = 3 → 0,1,2,3,3,3. Exactly one pulse, coincident with the first 3.
- One-shot down: load 4, one-cycle count_enable → busy the next cycle, count 3,2,1,0 then hold. Pulse and busy falling together at 0. A second count_enable is ignored. clear returns to IDLE with count 0.
- Priority and reset: clear with load_en and step asserted → count 0, no pulse. Asserting n_rst low mid-run in one-shot → count 0, busy 0 immediately.
- With FLEX_TIMER_PRESCALE_EN, prescale_val = 2, wrap up, rollover_val = 3 → count advances every 3rd cycle. The wrap pulse lands on cycle 12 after enable.

Source files
------------

// File: rtl/flex_timer.sv
// flex_timer: parametrised up/down counter/timer with wrap, saturate and one-shot modes.
// Defining FLEX_TIMER_PRESCALE_EN adds the prescale_val port and a P-bit tick prescaler.
module flex_timer #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load_en,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic [1:0]               mode,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
`ifdef FLEX_TIMER_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     rollover_pulse,
  output logic                     busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

  logic [1:0]              state, state_nxt;
  logic [NUM_CNT_BITS-1:0] count_nxt, stepped;
  logic pulse_nxt, one_shot, saturate, step_req, tick, step, at_term, next_term;

  assign one_shot = (mode == 2'b10);
  assign saturate = (mode == 2'b01);
  assign step_req = one_shot ? (state == ST_RUN) : count_enable;

  assign at_term       = count_down ? (count_out == '0) : (count_out >= rollover_val);
  assign rollover_flag = at_term;
  assign stepped       = count_down ? (count_out - ONE) : (count_out + ONE);
  assign next_term     = count_down ? (stepped == '0) : (stepped >= rollover_val);

`ifdef FLEX_TIMER_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] prescaler;

  assign tick = (prescaler == prescale_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      prescaler <= '0;
    else if (clear || load_en)
      prescaler <= '0;
    else if (step_req)
      prescaler <= tick ? '0 : prescaler + PRESCALE_BITS'(1);
  end
`else
  assign tick = 1'b1;
`endif

  assign step = step_req & tick;

  always_comb begin
    count_nxt = count_out;
    state_nxt = state;
    pulse_nxt = 1'b0;
    if (clear) begin
      count_nxt = '0;
      state_nxt = ST_IDLE;
    end else if (load_en) begin
      count_nxt = load_val;
      state_nxt = ST_IDLE;
    end else if (!one_shot) begin
      state_nxt = ST_IDLE;
      if (step) begin
        if (at_term) begin
          // Saturate holds silently; wrap reloads and reports the event
          if (!saturate) begin
            count_nxt = count_down ? rollover_val : '0;
            pulse_nxt = 1'b1;
          end
        end else begin
          count_nxt = stepped;
          pulse_nxt = saturate & next_term;
        end
      end
    end else begin
      case (state)
        ST_IDLE: if (count_enable) state_nxt = ST_RUN;
        ST_RUN: begin
          if (step) begin
            if (!at_term) count_nxt = stepped;
            if (at_term || next_term) begin
              state_nxt = ST_DONE;
              pulse_nxt = 1'b1;
            end
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out      <= '0;
      state          <= ST_IDLE;
      rollover_pulse <= 1'b0;
      busy           <= 1'b0;
    end else begin
      count_out      <= count_nxt;
      state          <= state_nxt;
      rollover_pulse <= pulse_nxt;
      busy           <= (state_nxt == ST_RUN);
    end
  end

endmodule
